pwmled_sequencer: RTL
=====================

Name: pwmled_sequencer

Overview:
- Avalon-MM slave PWM controller that drives the 8 LED outputs with per-channel brightness and a hardware fade engine.
- Sits on the motor-controller-core system bus, alongside the plain output PIO.
- Software writes target duty values. The block applies them synchronously at PWM period boundaries, either immediately or by ramping at a programmed step.

Parameters:
- CHANNELS, 8, number of LED channels; register map below is fixed for 8.
- PRESCALE_W, 16, width of the tick prescaler register.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  4  word address of the register.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write occurs when chipselect && !write_n.
- writedata  in  32  write data.
- readdata  out  32  combinational read of the addressed register; zero-extended.
- out_port  out  CHANNELS  registered PWM outputs, bit i = channel i.

Behaviour:
- Reset is asynchronous, active-high. All registers reset to 0, including out_port, the prescaler, the PWM counter, and current/target duties.
- Register map (word addresses). Writes to read-only or unmapped addresses are ignored; unmapped reads return 0.
  - 0 CONTROL (rw): bit0 enable, bit1 fade_en.
  - 1 PRESCALE (rw): bits[PRESCALE_W-1:0]. A tick is asserted every PRESCALE+1 clocks.
  - 2 FADE_STEP (rw): bits[7:0]; a step value of 0 is treated as 1.
  - 3 STATUS (ro): bit0 busy, set when any current duty != its target; bits[15:8] PWM counter value.
  - 4..11 TARGET0..7 (rw): bits[7:0] target duty for each channel.
- Prescaler:
  - Counts 0..PRESCALE and wraps; tick=1 on the clock where the count equals PRESCALE.
  - A write to PRESCALE resets the prescaler count to 0.
- PWM counter:
  - 8 bits; advances on each tick and runs 0..254, so one period is 255 ticks.
  - Period boundary = the tick on which the counter is 254; the counter wraps to 0 on that edge.
- Output:
  - out_port[i] <= enable && (pwm_cnt < current[i]), registered, so there is one clock of latency from pwm_cnt.
  - Duty 0 gives a constant low output; duty 255 gives a constant high output.
- Current duty update. Current duties are internal shadow registers, updated only at a period boundary, so a new value takes effect from pwm_cnt=0.
  - fade_en=0: current[i] <= target[i].
  - fade_en=1: current[i] moves toward target[i] by step, saturating exactly at target (no overshoot or wrap). If |target-current| < step, current becomes target.
- enable=0:
  - Prescaler and PWM counter are held at 0 and out_port is 0.
  - current[i] tracks target[i] every clock.
  - Re-enabling starts a fresh period at pwm_cnt=0, with current equal to target and no fade from the old value.
- Target rewritten mid-fade: the next boundary steps toward the new target from the present current value.
- Simultaneous TARGET write and period boundary: the update uses the old target; the new value applies at the following boundary.
- Clearing fade_en mid-fade: current jumps to target at the next boundary.
- Reset asserted mid-period: out_port goes to 0 immediately (asynchronously) and all state clears.

Test Plan:
- Reset, then read all addresses 0..15 -> every read is 0 and out_port=0; toggle reset mid-run with outputs active -> out_port=0 immediately.
- PRESCALE=0, TARGET0=128, CONTROL=1 -> out_port[0] high 128 of every 255 clocks (after the first boundary); TARGET1=255 -> out_port[1] constant high; TARGET2=0 -> out_port[2] constant low.
- PRESCALE=3 -> PWM period = 1020 clocks; STATUS[15:8] increments every 4 clocks; writing PRESCALE mid-count restarts the tick spacing.
- Fade, with CONTROL=3, FADE_STEP=50, TARGET0 0->200 -> current 50,100,150,200 over 4 boundaries with busy=1 throughout, then busy=0. Retarget to 30 mid-ramp at current=100 -> sequence 50, then 30, saturating with no undershoot.
- TARGET write landing on the same clock as a boundary, with CONTROL=1 -> old duty for one more period, new duty the period after; FADE_STEP=0 with fade -> steps of 1.
- Clear enable mid-period -> out_port=0 the next clock and counters at 0; re-enable -> period restarts at count 0 with current = target.

Source files
------------

// File: rtl/pwmled_sequencer.sv
// Avalon-MM PWM controller for the LED bank: per-channel duty with an optional fade engine.
// Duty changes land only at PWM period boundaries so a period is never split between two duties.
module pwmled_sequencer #(
    parameter int CHANNELS   = 8,
    parameter int PRESCALE_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          address,
    input  logic                chipselect,
    input  logic                write_n,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    output logic [CHANNELS-1:0] out_port
);

    logic                  r_enable;
    logic                  r_fadeEn;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [7:0]            r_fadeStep;
    logic [7:0]            r_target  [CHANNELS];
    logic [7:0]            r_current [CHANNELS];
    logic [PRESCALE_W-1:0] r_presCnt;
    logic [7:0]            r_pwmCnt;

    logic       w_write;
    logic       w_tick;
    logic       w_boundary;
    logic       w_busy;
    logic [7:0] w_step;
    logic [7:0] w_nextDuty [CHANNELS];
    logic       w_unused;

    assign w_write    = chipselect && !write_n;
    assign w_tick     = r_enable && (r_presCnt == r_prescale);
    assign w_boundary = w_tick && (r_pwmCnt == 8'd254);
    assign w_step     = (r_fadeStep == 8'd0) ? 8'd1 : r_fadeStep;
    assign w_unused   = ^writedata[31:16];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_enable   <= 1'b0;
            r_fadeEn   <= 1'b0;
            r_prescale <= '0;
            r_fadeStep <= '0;
            for (int i = 0; i < CHANNELS; i++) r_target[i] <= '0;
        end else if (w_write) begin
            case (address)
                4'd0: begin
                    r_enable <= writedata[0];
                    r_fadeEn <= writedata[1];
                end
                4'd1: r_prescale <= writedata[PRESCALE_W-1:0];
                4'd2: r_fadeStep <= writedata[7:0];
                default: begin
                    for (int i = 0; i < CHANNELS; i++)
                        if (address == 4'(i + 4)) r_target[i] <= writedata[7:0];
                end
            endcase
        end
    end

    // A PRESCALE write restarts the tick spacing so the new rate begins cleanly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presCnt <= '0;
            r_pwmCnt  <= '0;
        end else if (!r_enable) begin
            r_presCnt <= '0;
            r_pwmCnt  <= '0;
        end else begin
            if ((w_write && address == 4'd1) || w_tick) r_presCnt <= '0;
            else                                        r_presCnt <= r_presCnt + PRESCALE_W'(1);
            if (w_tick) r_pwmCnt <= (r_pwmCnt == 8'd254) ? 8'd0 : r_pwmCnt + 8'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            w_nextDuty[i] = r_target[i];
            if (r_fadeEn) begin
                if (r_target[i] > r_current[i]) begin
                    if (r_target[i] - r_current[i] > w_step) w_nextDuty[i] = r_current[i] + w_step;
                end else if (r_current[i] - r_target[i] > w_step) begin
                    w_nextDuty[i] = r_current[i] - w_step;
                end
            end
        end
    end

    // While disabled the shadow duty follows the target, so re-enabling never fades from a stale value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) r_current[i] <= '0;
        end else if (!r_enable) begin
            for (int i = 0; i < CHANNELS; i++) r_current[i] <= r_target[i];
        end else if (w_boundary) begin
            for (int i = 0; i < CHANNELS; i++) r_current[i] <= w_nextDuty[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_port <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++)
                out_port[i] <= r_enable && (r_pwmCnt < r_current[i]);
        end
    end

    always_comb begin
        w_busy = 1'b0;
        for (int i = 0; i < CHANNELS; i++)
            if (r_current[i] != r_target[i]) w_busy = 1'b1;
    end

    always_comb begin
        readdata = '0;
        case (address)
            4'd0: readdata = {30'd0, r_fadeEn, r_enable};
            4'd1: readdata[PRESCALE_W-1:0] = r_prescale;
            4'd2: readdata[7:0] = r_fadeStep;
            4'd3: readdata = {16'd0, r_pwmCnt, 7'd0, w_busy};
            default: begin
                for (int i = 0; i < CHANNELS; i++)
                    if (address == 4'(i + 4)) readdata[7:0] = r_target[i];
            end
        endcase
    end

endmodule
